// File: rtl/alu_seq.sv
// alu_seq: multi-cycle integer ALU (RV32I-style single-cycle ops plus RV32M
// multiply/divide) with valid/ready handshakes on both sides.
// Optional feature macro: ALU_SEQ_FAST_MUL_EN selects a one-cycle
// combinational multiplier instead of the iterative shift-add unit.
module alu_seq #(
    parameter int XLEN = 32,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      operator,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            result_is_zero,
    output logic            illegal_op
);

    localparam int CW = SHW + 1;
    localparam int PW = 2 * XLEN;

    localparam logic [XLEN-1:0] ZERO_X = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES_X = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [PW-1:0]   ZERO_P = {PW{1'b0}};
    localparam logic [PW-1:0]   ONE_P  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0]   ONE_C  = {{(CW-1){1'b0}}, 1'b1};

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_XOR    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_AND    = 5'd4;
    localparam logic [4:0] OP_SLL    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_SLT    = 5'd8;
    localparam logic [4:0] OP_SLTU   = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Magnitude of a value that is signed when sgn is set.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? (~v + ONE_X) : v;
    endfunction

    // Two's-complement negation helpers for single and double width.
    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
        return ~v + ONE_X;
    endfunction

    function automatic logic [PW-1:0] neg_p(input logic [PW-1:0] v);
        return ~v + ONE_P;
    endfunction

    // Result of the single-cycle group; shifts look at the low SHW bits only.
    function automatic logic [XLEN-1:0] single_op(input logic [4:0] op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        logic [SHW-1:0]  sh;
        logic [XLEN-1:0] r;
        sh = b[SHW-1:0];
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_XOR:  r = a ^ b;
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = $signed(a) >>> sh;
            OP_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
            default: r = ZERO_X;
        endcase
        return r;
    endfunction

    state_t          state_r, state_nx_s;
    logic [4:0]      op_r, op_nx_s;
    logic [CW-1:0]   cnt_r, cnt_nx_s;
    logic            qneg_r, qneg_nx_s;     // negate product / quotient at the end
    logic            rneg_r, rneg_nx_s;     // negate remainder at the end
    logic [PW-1:0]   mcand_r, mcand_nx_s;
    logic [XLEN-1:0] mplier_r, mplier_nx_s;
`ifndef ALU_SEQ_FAST_MUL_EN
    logic [PW-1:0]   prod_r, prod_nx_s;
`endif
    logic [XLEN-1:0] divisor_r, divisor_nx_s;
    logic [XLEN-1:0] quot_r, quot_nx_s;
    logic [XLEN-1:0] rem_r, rem_nx_s;
    logic [XLEN-1:0] result_r, result_nx_s;
    logic            zero_r, zero_nx_s;
    logic            illegal_r, illegal_nx_s;

    logic            accept_s;
    logic            load_s;
    logic            ill_s;
    logic [XLEN-1:0] res_s;
    logic            a_sgn_s, b_sgn_s, d_sgn_s, is_quot_s;
    logic [PW-1:0]   prod_s, prod_fin_s;
    logic [XLEN:0]   div_shift_s, div_diff_s;
    logic            div_ge_s;
    logic [XLEN-1:0] rem_step_s, quot_step_s;

    assign in_ready       = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
    assign accept_s       = in_valid && in_ready;
    assign out_valid      = (state_r == ST_DONE);
    assign result         = result_r;
    assign result_is_zero = zero_r;
    assign illegal_op     = illegal_r;

    // Next-state and datapath update for the whole operation sequence.
    always_comb begin
        state_nx_s   = state_r;
        op_nx_s      = op_r;
        cnt_nx_s     = cnt_r;
        qneg_nx_s    = qneg_r;
        rneg_nx_s    = rneg_r;
        mcand_nx_s   = mcand_r;
        mplier_nx_s  = mplier_r;
`ifndef ALU_SEQ_FAST_MUL_EN
        prod_nx_s    = prod_r;
`endif
        divisor_nx_s = divisor_r;
        quot_nx_s    = quot_r;
        rem_nx_s     = rem_r;
        load_s       = 1'b0;
        ill_s        = 1'b0;
        res_s        = ZERO_X;
        prod_s       = ZERO_P;
        prod_fin_s   = ZERO_P;
        div_shift_s  = {1'b0, ZERO_X};
        div_diff_s   = {1'b0, ZERO_X};
        div_ge_s     = 1'b0;
        rem_step_s   = ZERO_X;
        quot_step_s  = ZERO_X;
        a_sgn_s      = (operator == OP_MULH) || (operator == OP_MULHSU);
        b_sgn_s      = (operator == OP_MULH);
        d_sgn_s      = (operator == OP_DIV) || (operator == OP_REM);
        is_quot_s    = (operator == OP_DIV) || (operator == OP_DIVU);

        case (state_r)
            ST_IDLE: begin
                state_nx_s = ST_IDLE;
            end
            ST_MUL: begin
`ifdef ALU_SEQ_FAST_MUL_EN
                prod_s     = mcand_r * {{XLEN{1'b0}}, mplier_r};
                prod_fin_s = qneg_r ? neg_p(prod_s) : prod_s;
                res_s      = (op_r == OP_MUL) ? prod_fin_s[XLEN-1:0] : prod_fin_s[PW-1:XLEN];
                load_s     = 1'b1;
                state_nx_s = ST_DONE;
`else
                prod_s      = prod_r + (mplier_r[0] ? mcand_r : ZERO_P);
                prod_nx_s   = prod_s;
                mcand_nx_s  = {mcand_r[PW-2:0], 1'b0};
                mplier_nx_s = {1'b0, mplier_r[XLEN-1:1]};
                cnt_nx_s    = (cnt_r != ZERO_C) ? (cnt_r - ONE_C) : ZERO_C;
                if (cnt_r <= ONE_C) begin
                    prod_fin_s = qneg_r ? neg_p(prod_s) : prod_s;
                    res_s      = (op_r == OP_MUL) ? prod_fin_s[XLEN-1:0] : prod_fin_s[PW-1:XLEN];
                    load_s     = 1'b1;
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_MUL;
                end
`endif
            end
            ST_DIV: begin
                // Restoring step: shift in the next dividend bit, subtract if it fits.
                div_shift_s = {rem_r, quot_r[XLEN-1]};
                div_diff_s  = div_shift_s - {1'b0, divisor_r};
                div_ge_s    = ~div_diff_s[XLEN];
                rem_step_s  = div_ge_s ? div_diff_s[XLEN-1:0] : div_shift_s[XLEN-1:0];
                quot_step_s = {quot_r[XLEN-2:0], div_ge_s};
                rem_nx_s    = rem_step_s;
                quot_nx_s   = quot_step_s;
                cnt_nx_s    = (cnt_r != ZERO_C) ? (cnt_r - ONE_C) : ZERO_C;
                if (cnt_r <= ONE_C) begin
                    if ((op_r == OP_DIV) || (op_r == OP_DIVU)) begin
                        res_s = qneg_r ? neg_x(quot_step_s) : quot_step_s;
                    end else begin
                        res_s = rneg_r ? neg_x(rem_step_s) : rem_step_s;
                    end
                    load_s     = 1'b1;
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_DIV;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase

        // A new accept (only possible in IDLE or DONE) overrides the above.
        if (accept_s) begin
            op_nx_s  = operator;
            cnt_nx_s = CW'(XLEN);
            if (operator[4:2] == 3'b100) begin
                mcand_nx_s  = {{XLEN{1'b0}}, mag(operand1, a_sgn_s)};
                mplier_nx_s = mag(operand2, b_sgn_s);
                qneg_nx_s   = (a_sgn_s & operand1[XLEN-1]) ^ (b_sgn_s & operand2[XLEN-1]);
`ifndef ALU_SEQ_FAST_MUL_EN
                prod_nx_s   = ZERO_P;
`endif
                state_nx_s  = ST_MUL;
            end else if (operator[4:2] == 3'b101) begin
                if (operand2 == ZERO_X) begin
                    res_s      = is_quot_s ? ONES_X : operand1;
                    load_s     = 1'b1;
                    state_nx_s = ST_DONE;
                end else if (d_sgn_s && (operand1 == MIN_X) && (operand2 == ONES_X)) begin
                    res_s      = is_quot_s ? operand1 : ZERO_X;
                    load_s     = 1'b1;
                    state_nx_s = ST_DONE;
                end else begin
                    divisor_nx_s = mag(operand2, d_sgn_s);
                    quot_nx_s    = mag(operand1, d_sgn_s);
                    rem_nx_s     = ZERO_X;
                    qneg_nx_s    = d_sgn_s & (operand1[XLEN-1] ^ operand2[XLEN-1]);
                    rneg_nx_s    = d_sgn_s & operand1[XLEN-1];
                    state_nx_s   = ST_DIV;
                end
            end else if (operator < 5'd10) begin
                res_s      = single_op(operator, operand1, operand2);
                load_s     = 1'b1;
                state_nx_s = ST_DONE;
            end else begin
                res_s      = ZERO_X;
                ill_s      = 1'b1;
                load_s     = 1'b1;
                state_nx_s = ST_DONE;
            end
        end else begin
            op_nx_s = op_nx_s;
        end

        if (load_s) begin
            result_nx_s  = res_s;
            zero_nx_s    = (res_s == ZERO_X);
            illegal_nx_s = ill_s;
        end else begin
            result_nx_s  = result_r;
            zero_nx_s    = zero_r;
            illegal_nx_s = illegal_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Operand, iteration and result registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            op_r      <= 5'd0;
            cnt_r     <= ZERO_C;
            qneg_r    <= 1'b0;
            rneg_r    <= 1'b0;
            mcand_r   <= ZERO_P;
            mplier_r  <= ZERO_X;
`ifndef ALU_SEQ_FAST_MUL_EN
            prod_r    <= ZERO_P;
`endif
            divisor_r <= ZERO_X;
            quot_r    <= ZERO_X;
            rem_r     <= ZERO_X;
            result_r  <= ZERO_X;
            zero_r    <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            op_r      <= op_nx_s;
            cnt_r     <= cnt_nx_s;
            qneg_r    <= qneg_nx_s;
            rneg_r    <= rneg_nx_s;
            mcand_r   <= mcand_nx_s;
            mplier_r  <= mplier_nx_s;
`ifndef ALU_SEQ_FAST_MUL_EN
            prod_r    <= prod_nx_s;
`endif
            divisor_r <= divisor_nx_s;
            quot_r    <= quot_nx_s;
            rem_r     <= rem_nx_s;
            result_r  <= result_nx_s;
            zero_r    <= zero_nx_s;
            illegal_r <= illegal_nx_s;
        end
    end

endmodule
